// File: rtl/rfphoenix_vec_perm_reduce_if.sv
// ---------------------------------------------------------------------------
// rfphoenix_vec_perm_reduce_if
//   Request/response bundle for the vector permute/reduce unit.
//
//   Handshake: both channels use strict valid/ready semantics. A transfer
//   happens on a rising clock edge where valid && ready are both 1. Once
//   valid is raised, the driver holds it and keeps the payload stable until
//   the transfer happens. ready may depend on state but never on valid.
//
//   Request channel  : in_valid, in_ready, op, mask, sel, a, b, c
//   Response channel : out_valid, out_ready, o
//
//   modport master : the requester (execute stage / testbench)
//   modport slave  : the permute/reduce unit
// ---------------------------------------------------------------------------
interface rfphoenix_vec_perm_reduce_if #(
  parameter int NLANES = 16,
  parameter int LANE_W = 32,
  parameter int SELW   = $clog2(NLANES) + 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               op;
  logic [NLANES-1:0]        mask;
  logic [SELW-1:0]          sel;
  logic [NLANES*LANE_W-1:0] a;
  logic [NLANES*LANE_W-1:0] b;
  logic [NLANES*LANE_W-1:0] c;
  logic                     out_valid;
  logic                     out_ready;
  logic [NLANES*LANE_W-1:0] o;

  modport master (
    output in_valid, op, mask, sel, a, b, c, out_ready,
    input  in_ready, out_valid, o
  );

  modport slave (
    input  in_valid, op, mask, sel, a, b, c, out_ready,
    output in_ready, out_valid, o
  );
endinterface

// File: rtl/rfphoenix_vec_perm_reduce.sv
// ---------------------------------------------------------------------------
// rfphoenix_vec_perm_reduce
//   Multi-cycle cross-lane unit of the vector execute stage. Handles the
//   permutes (VEX, VSHUF, VSLL, VSRL, VROT) with per-lane merge masking and
//   the horizontal reductions (VRSUM, VRMAX, VRMIN). LPC lanes are handled
//   per cycle, so a request takes NLANES/LPC cycles in RUN.
//
//   Ports
//     clk, rst   : clock, synchronous active-high reset
//     bus        : request/response channels (slave side), see the interface
//     dbg_state  : current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
//   Operands are captured on accept, so the requester may change its
//   inputs freely while the unit is busy.
// ---------------------------------------------------------------------------
module rfphoenix_vec_perm_reduce #(
  parameter int NLANES = 16,
  parameter int LANE_W = 32,
  parameter int LPC    = 4,
  parameter int SELW   = $clog2(NLANES) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  rfphoenix_vec_perm_reduce_if.slave    bus,
  output logic [1:0]                    dbg_state
);

  localparam int LW     = $clog2(NLANES);
  localparam int NCHUNK = NLANES / LPC;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [2:0] OP_VEX   = 3'd0;
  localparam logic [2:0] OP_VSHUF = 3'd1;
  localparam logic [2:0] OP_VSLL  = 3'd2;
  localparam logic [2:0] OP_VSRL  = 3'd3;
  localparam logic [2:0] OP_VROT  = 3'd4;
  localparam logic [2:0] OP_VRSUM = 3'd5;
  localparam logic [2:0] OP_VRMAX = 3'd6;
  localparam logic [2:0] OP_VRMIN = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured operands. For b only the bits a shuffle looks at are kept:
  // the zeroing flag (MSB) and the lane index (low LW bits).
  logic [2:0]        op_q;
  logic [NLANES-1:0] mask_q;
  logic [SELW-1:0]   sel_q;
  logic [LANE_W-1:0] a_q   [NLANES];
  logic              bz_q  [NLANES];
  logic [LW-1:0]     bi_q  [NLANES];
  logic [LANE_W-1:0] c_q   [NLANES];

  logic [LANE_W-1:0] res_q [NLANES];
  logic [LANE_W-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q;

  logic              accept;
  logic              last_chunk;
  logic              is_red;
  logic [LANE_W-1:0] lane_val [LPC];

  // Starting accumulator value: the identity of the reduction.
  function automatic logic [LANE_W-1:0] red_identity(input logic [2:0] op);
    logic [LANE_W-1:0] r;
    r = '0;
    case (op)
      OP_VRMAX: r = {1'b1, {(LANE_W-1){1'b0}}};
      OP_VRMIN: r = {1'b0, {(LANE_W-1){1'b1}}};
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign is_red     = (op_q >= OP_VRSUM);
  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_chunk) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign dbg_state     = state_q;

  // -------------------------------------------------------------------------
  // Per-chunk datapath: output lanes n = cnt_q*LPC + j.
  // -------------------------------------------------------------------------
  always_comb begin : chunk_logic
    int                n;
    int                s;
    logic [LW-1:0]     ln;
    logic [LW-1:0]     src;
    logic              zero;
    logic [LANE_W-1:0] v;
    n     = 0;
    s     = int'(sel_q);
    ln    = '0;
    src   = '0;
    zero  = 1'b0;
    v     = '0;
    acc_d = acc_q;
    for (int j = 0; j < LPC; j++) lane_val[j] = '0;

    for (int j = 0; j < LPC; j++) begin
      n    = int'(cnt_q) * LPC + j;
      ln   = LW'(n);
      zero = 1'b0;
      src  = '0;
      // Out-of-range source indices are flagged via zero before the
      // truncating cast, so the cast value is only used when in range.
      // VROT relies on the truncation for the modulo (NLANES is 2^LW).
      case (op_q)
        OP_VEX:   begin zero = (s >= NLANES);     src = LW'(s);     end
        OP_VSHUF: begin zero = bz_q[ln];          src = bi_q[ln];   end
        OP_VSLL:  begin zero = (n < s);           src = LW'(n - s); end
        OP_VSRL:  begin zero = (n + s >= NLANES); src = LW'(n + s); end
        OP_VROT:  begin zero = 1'b0;              src = LW'(n + s); end
        default:  begin zero = 1'b1;              src = '0;         end
      endcase
      v           = zero ? '0 : a_q[src];
      lane_val[j] = mask_q[ln] ? v : c_q[ln];

      // Reductions walk the same lanes as source lanes.
      if (mask_q[ln]) begin
        case (op_q)
          OP_VRSUM: acc_d = acc_d + a_q[ln];
          OP_VRMAX: if ($signed(a_q[ln]) > $signed(acc_d)) acc_d = a_q[ln];
          OP_VRMIN: if ($signed(a_q[ln]) < $signed(acc_d)) acc_d = a_q[ln];
          default:  acc_d = acc_d;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Operand capture, chunk counter, accumulator and result register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      mask_q <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      for (int n = 0; n < NLANES; n++) begin
        a_q[n]   <= '0;
        bz_q[n]  <= 1'b0;
        bi_q[n]  <= '0;
        c_q[n]   <= '0;
        res_q[n] <= '0;
      end
    end else if (accept) begin
      op_q   <= bus.op;
      mask_q <= bus.mask;
      sel_q  <= bus.sel;
      cnt_q  <= '0;
      acc_q  <= red_identity(bus.op);
      for (int n = 0; n < NLANES; n++) begin
        a_q[n]  <= bus.a[n*LANE_W +: LANE_W];
        bz_q[n] <= bus.b[n*LANE_W + LANE_W - 1];
        bi_q[n] <= bus.b[n*LANE_W +: LW];
        c_q[n]  <= bus.c[n*LANE_W +: LANE_W];
      end
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= acc_d;
      if (is_red) begin
        // Reduction result lands in lane 0 with every other lane cleared;
        // the merge vector is not used.
        if (last_chunk) begin
          for (int n = 1; n < NLANES; n++) res_q[n] <= '0;
          res_q[0] <= acc_d;
        end
      end else begin
        for (int j = 0; j < LPC; j++) res_q[LW'(int'(cnt_q) * LPC + j)] <= lane_val[j];
      end
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_out
    assign bus.o[g*LANE_W +: LANE_W] = res_q[g];
  end

endmodule

// File: tb/tb_rfphoenix_vec_perm_reduce.sv
module tb_rfphoenix_vec_perm_reduce;
  localparam int NL   = 16;
  localparam int LW   = 32;
  localparam int LPC  = 4;
  localparam int SELW = $clog2(NL) + 1;
  localparam int VW   = NL * LW;
  localparam int LAT  = NL / LPC + 1;

  typedef logic [LW-1:0] lane_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rfphoenix_vec_perm_reduce_if #(.NLANES(NL), .LANE_W(LW), .SELW(SELW)) bus ();
  logic [1:0] dbg_state;

  rfphoenix_vec_perm_reduce #(.NLANES(NL), .LANE_W(LW), .LPC(LPC), .SELW(SELW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [VW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic lane_t lane_of(input logic [VW-1:0] v, input int n);
    return v[n*LW +: LW];
  endfunction

  function automatic logic [VW-1:0] model(input logic [2:0] op, input logic [NL-1:0] m,
                                          input int sel, input logic [VW-1:0] av,
                                          input logic [VW-1:0] bv, input logic [VW-1:0] cv);
    logic [VW-1:0]     r;
    logic signed [LW-1:0] acc;
    logic signed [LW-1:0] x;
    lane_t             bl;
    int                src;
    bit                zero;
    lane_t             val;
    r = '0;
    if (op >= 3'd5) begin
      if (op == 3'd5)      acc = 0;
      else if (op == 3'd6) acc = 32'sh8000_0000;
      else                 acc = 32'sh7FFF_FFFF;
      for (int n = 0; n < NL; n++) begin
        if (m[n]) begin
          x = $signed(lane_of(av, n));
          if (op == 3'd5)                acc = acc + x;
          else if (op == 3'd6 && x > acc) acc = x;
          else if (op == 3'd7 && x < acc) acc = x;
        end
      end
      r[LW-1:0] = acc;
    end else begin
      for (int n = 0; n < NL; n++) begin
        src = 0; zero = 0;
        case (op)
          3'd0: begin src = sel; zero = (sel >= NL); end
          3'd1: begin bl = lane_of(bv, n); zero = bl[LW-1]; src = int'(bl) % NL; end
          3'd2: begin src = n - sel; zero = (n < sel); end
          3'd3: begin src = n + sel; zero = (src >= NL); end
          default: begin src = (n + sel) % NL; zero = 0; end
        endcase
        val = zero ? '0 : lane_of(av, src);
        r[n*LW +: LW] = m[n] ? val : lane_of(cv, n);
      end
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int n = 0; n < NL; n++) v[n*LW +: LW] = $urandom;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.mask      = '0;
    bus.sel       = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c         = '0;
    bus.out_ready = 1'b0;
  endtask

  // Present one request, wait for acceptance, scramble the inputs during
  // RUN, then wait for out_valid. lat counts cycles from accept cycle T.
  task automatic issue(input logic [2:0] op, input logic [NL-1:0] m, input int sel,
                       input logic [VW-1:0] av, input logic [VW-1:0] bv,
                       input logic [VW-1:0] cv, output logic [VW-1:0] got,
                       output int lat);
    int w;
    @(negedge clk);
    bus.op = op; bus.mask = m; bus.sel = SELW'(sel);
    bus.a = av; bus.b = bv; bus.c = cv;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom); bus.mask = NL'($urandom); bus.sel = SELW'($urandom);
    bus.a = rand_vec(); bus.b = rand_vec(); bus.c = rand_vec();
    lat = 1;
    while (!bus.out_valid && lat < 50) begin @(negedge clk); lat++; end
    got = bus.o;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.o !== '0) $display("FAIL reset_o got %h exp 0", bus.o); else n_pass++;
  endtask

  task automatic test_vex();
    logic [VW-1:0] av, got, e;
    int lat;
    for (int n = 0; n < NL; n++) av[n*LW +: LW] = lane_t'(n + 100);
    exp_q.push_back(model(3'd0, '1, 5, av, '0, '0));
    issue(3'd0, '1, 5, av, '0, '0, got, lat);
    e = exp_q.pop_front();
    n_checks++; if (got !== e) $display("FAIL vex_sel5 got %h exp %h", got, e); else n_pass++;
    n_checks++; if (lane_of(got, 9) !== 32'd105) $display("FAIL vex_lane9 got %0d exp 105", lane_of(got, 9)); else n_pass++;
    n_checks++; if (lat !== LAT) $display("FAIL vex_latency got %0d exp %0d", lat, LAT); else n_pass++;
    consume();
    exp_q.push_back(model(3'd0, '1, 16, av, '0, '0));
    issue(3'd0, '1, 16, av, '0, '0, got, lat);
    e = exp_q.pop_front();
    n_checks++; if (got !== '0 || got !== e) $display("FAIL vex_sel16 got %h exp %h", got, e); else n_pass++;
    consume();
  endtask

  task automatic test_vshuf();
    logic [VW-1:0] av, bv, cv, got, e;
    int lat;
    for (int n = 0; n < NL; n++) begin
      av[n*LW +: LW] = lane_t'(n);
      bv[n*LW +: LW] = lane_t'(15 - n);
      cv[n*LW +: LW] = lane_t'(32'hC0 + n);
    end
    bv[3*LW +: LW] = 32'h8000_0000;
    exp_q.push_back(model(3'd1, 16'hFFF7, 0, av, bv, cv));
    issue(3'd1, 16'hFFF7, 0, av, bv, cv, got, lat);
    e = exp_q.pop_front();
    n_checks++; if (got !== e) $display("FAIL vshuf got %h exp %h", got, e); else n_pass++;
    n_checks++; if (lane_of(got, 3) !== 32'hC3) $display("FAIL vshuf_merge3 got %h exp c3", lane_of(got, 3)); else n_pass++;
    n_checks++; if (lane_of(got, 0) !== 32'd15) $display("FAIL vshuf_lane0 got %0d exp 15", lane_of(got, 0)); else n_pass++;
    consume();
  endtask

  task automatic test_shift_rot();
    logic [VW-1:0] av, got, e;
    int lat;
    av = rand_vec();
    exp_q.push_back(model(3'd2, '1, 2, av, '0, '0));
    issue(3'd2, '1, 2, av, '0, '0, got, lat);
    e = exp_q.pop_front();
    n_checks++; if (got !== e) $display("FAIL vsll2 got %h exp %h", got, e); else n_pass++;
    n_checks++; if (lane_of(got, 1) !== '0 || lane_of(got, 2) !== lane_of(av, 0))
      $display("FAIL vsll2_edge got %h,%h exp 0,%h", lane_of(got, 1), lane_of(got, 2), lane_of(av, 0)); else n_pass++;
    consume();
    exp_q.push_back(model(3'd4, '1, 3, av, '0, '0));
    issue(3'd4, '1, 3, av, '0, '0, got, lat);
    e = exp_q.pop_front();
    n_checks++; if (got !== e) $display("FAIL vrot3 got %h exp %h", got, e); else n_pass++;
    n_checks++; if (lane_of(got, 15) !== lane_of(av, 2)) $display("FAIL vrot3_lane15 got %h exp %h", lane_of(got, 15), lane_of(av, 2)); else n_pass++;
    consume();
    exp_q.push_back(model(3'd3, '1, 16, av, '0, '0));
    issue(3'd3, '1, 16, av, '0, '0, got, lat);
    e = exp_q.pop_front();
    n_checks++; if (got !== '0 || got !== e) $display("FAIL vsrl16 got %h exp %h", got, e); else n_pass++;
    consume();
  endtask

  task automatic test_reduce();
    logic [VW-1:0] av, cv, got, e;
    int lat;
    cv = rand_vec();
    for (int n = 0; n < NL; n++) av[n*LW +: LW] = 32'h4000_0000;
    exp_q.push_back(model(3'd5, 16'h000F, 0, av, '0, cv));
    issue(3'd5, 16'h000F, 0, av, '0, cv, got, lat);
    e = exp_q.pop_front();
    n_checks++; if (got !== '0 || got !== e) $display("FAIL vrsum_wrap got %h exp %h", got, e); else n_pass++;
    consume();
    av = rand_vec();
    av[0*LW +: LW] = -32'sd5;
    av[1*LW +: LW] = -32'sd2;
    exp_q.push_back(model(3'd6, 16'h0003, 0, av, '0, cv));
    issue(3'd6, 16'h0003, 0, av, '0, cv, got, lat);
    e = exp_q.pop_front();
    n_checks++; if (got !== e) $display("FAIL vrmax got %h exp %h", got, e); else n_pass++;
    n_checks++; if (lane_of(got, 0) !== 32'hFFFF_FFFE) $display("FAIL vrmax_lane0 got %h exp fffffffe", lane_of(got, 0)); else n_pass++;
    consume();
    exp_q.push_back(model(3'd7, '0, 0, av, '0, cv));
    issue(3'd7, '0, 0, av, '0, cv, got, lat);
    e = exp_q.pop_front();
    n_checks++; if (got !== e || lane_of(got, 0) !== 32'h7FFF_FFFF) $display("FAIL vrmin_empty got %h exp %h", got, e); else n_pass++;
    consume();
  endtask

  task automatic test_handshake();
    logic [VW-1:0] av, av2, got, got2, e;
    int lat;
    bit stable;
    av = rand_vec(); av2 = rand_vec();
    exp_q.push_back(model(3'd4, 16'hA5A5, 7, av, '0, av2));
    issue(3'd4, 16'hA5A5, 7, av, '0, av2, got, lat);
    e = exp_q.pop_front();
    n_checks++; if (got !== e) $display("FAIL hs_first got %h exp %h", got, e); else n_pass++;
    // New request presented while the result is held back.
    bus.op = 3'd2; bus.mask = '1; bus.sel = SELW'(1); bus.a = av2; bus.b = '0; bus.c = '0;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(3'd2, '1, 1, av2, '0, '0));
    stable = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.o !== got || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) stable = 0;
    end
    n_checks++; if (!stable) $display("FAIL hs_hold got o=%h rdy=%b vld=%b exp o=%h rdy=0 vld=1", bus.o, bus.in_ready, bus.out_valid, got); else n_pass++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL hs_idle got rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid); else n_pass++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL hs_accepted got rdy=%b exp 0", bus.in_ready); else n_pass++;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin @(negedge clk); lat++; end
    got2 = bus.o;
    e = exp_q.pop_front();
    n_checks++; if (got2 !== e || lat !== LAT) $display("FAIL hs_second got %h lat %0d exp %h lat %0d", got2, lat, e, LAT); else n_pass++;
    consume();
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    bus.op = 3'd0; bus.mask = '1; bus.sel = SELW'(1); bus.a = rand_vec(); bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.o !== '0)
      $display("FAIL midrst_idle got rdy=%b vld=%b o=%h exp rdy=1 vld=0 o=0", bus.in_ready, bus.out_valid, bus.o); else n_pass++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1;
    end
    n_checks++; if (seen) $display("FAIL midrst_no_valid got 1 exp 0"); else n_pass++;
  endtask

  task automatic test_random();
    logic [VW-1:0] av, bv, cv, got, e;
    logic [2:0] op;
    logic [NL-1:0] m;
    int sel, lat;
    for (int t = 0; t < 40; t++) begin
      op = 3'($urandom_range(0, 7));
      m = NL'($urandom);
      sel = $urandom_range(0, 2 * NL - 1);
      av = rand_vec(); bv = rand_vec(); cv = rand_vec();
      exp_q.push_back(model(op, m, sel, av, bv, cv));
      issue(op, m, sel, av, bv, cv, got, lat);
      e = exp_q.pop_front();
      n_checks++; if (got !== e || lat !== LAT)
        $display("FAIL rand_op%0d got %h lat %0d exp %h lat %0d", op, got, lat, e, LAT); else n_pass++;
      consume();
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_vex();
    test_vshuf();
    test_shift_rot();
    test_reduce();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
